// File: rtl/paquete_condicion.sv
// Shared constants for the conditional-execution stage and its users.
//   COND_EQ..COND_NV : ARM 4-bit condition-field encodings
//   IDX_N/Z/C/V      : bit positions of each flag inside an NZCV vector
//   NZCV_W, CNT_W    : flag-vector and statistics-counter widths
package paquete_condicion;

    localparam int unsigned NZCV_W = 4;
    localparam int unsigned COND_W = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [1:0] IDX_N = 2'd3;
    localparam logic [1:0] IDX_Z = 2'd2;
    localparam logic [1:0] IDX_C = 2'd1;
    localparam logic [1:0] IDX_V = 2'd0;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;
    localparam logic [COND_W-1:0] COND_NV = 4'b1111;

endpackage

// File: rtl/evaluador_condicion_if.sv
// Handshake bundle between ALU, conditional-execution stage and writeback.
//   upstream  : in_valid/in_ready, in_cond, in_setflags, in_resultado, ALU flags
//   downstream: out_valid/out_ready, out_ejecutar, out_resultado
// Modports: slave = the stage itself, master = the environment driving it.
interface evaluador_condicion_if #(
    parameter int unsigned N = 8
);
    import paquete_condicion::*;

    logic              in_valid;
    logic              in_ready;
    logic [COND_W-1:0] in_cond;
    logic              in_setflags;
    logic [N-1:0]      in_resultado;
    logic              in_flagNegativo;
    logic              in_flagCero;
    logic              in_flagCarry;
    logic              in_flagOverflow;

    logic              out_valid;
    logic              out_ready;
    logic              out_ejecutar;
    logic [N-1:0]      out_resultado;

    modport slave (
        input  in_valid, in_cond, in_setflags, in_resultado,
               in_flagNegativo, in_flagCero, in_flagCarry, in_flagOverflow,
               out_ready,
        output in_ready, out_valid, out_ejecutar, out_resultado
    );

    modport master (
        output in_valid, in_cond, in_setflags, in_resultado,
               in_flagNegativo, in_flagCero, in_flagCarry, in_flagOverflow,
               out_ready,
        input  in_ready, out_valid, out_ejecutar, out_resultado
    );

endinterface

// File: rtl/evaluar_condicion.sv
// Combinational ARM condition check: does `cond` pass against flags `nzcv`?
//   cond   : 4-bit condition field
//   nzcv   : {N,Z,C,V}
//   pass_c : 1 when the instruction must execute
module evaluar_condicion
    import paquete_condicion::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [NZCV_W-1:0] nzcv,
    output logic              pass_c
);

    logic n, z, c, v;

    always_comb begin
        n      = nzcv[IDX_N];
        z      = nzcv[IDX_Z];
        c      = nzcv[IDX_C];
        v      = nzcv[IDX_V];
        pass_c = 1'b0;
        case (cond)
            COND_EQ: pass_c = z;
            COND_NE: pass_c = !z;
            COND_CS: pass_c = c;
            COND_CC: pass_c = !c;
            COND_MI: pass_c = n;
            COND_PL: pass_c = !n;
            COND_VS: pass_c = v;
            COND_VC: pass_c = !v;
            COND_HI: pass_c = c && !z;
            COND_LS: pass_c = !c || z;
            COND_GE: pass_c = (n == v);
            COND_LT: pass_c = (n != v);
            COND_GT: pass_c = !z && (n == v);
            COND_LE: pass_c = z || (n != v);
            COND_AL: pass_c = 1'b1;
            default: pass_c = 1'b0;  // NV never executes
        endcase
    end

endmodule

// File: rtl/evaluador_condicion.sv
// Conditional-execution stage: holds architectural NZCV, decides whether each
// ALU result commits, and updates flags only for executed S-instructions.
// Single output register with valid/ready on both sides.
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : upstream/downstream handshake and payload
//   flags_nzcv     : architectural flags {N,Z,C,V}
//   cnt_ejecutadas, cnt_anuladas : saturating accept statistics, present only
//                    when EVALUADOR_CONTADORES_EN is defined
module evaluador_condicion
    import paquete_condicion::*;
(
    input  logic               clk,
    input  logic               rst_n,
    evaluador_condicion_if.slave bus,
    output logic [NZCV_W-1:0]  flags_nzcv
`ifdef EVALUADOR_CONTADORES_EN
    ,
    output logic [CNT_W-1:0]   cnt_ejecutadas,
    output logic [CNT_W-1:0]   cnt_anuladas
`endif
);

    logic pass_c;
    logic accept_c;

    // Evaluated against the current flag register; a dependent instruction in
    // the next cycle sees the value written at this accept edge.
    evaluar_condicion u_evaluar (
        .cond   (bus.in_cond),
        .nzcv   (flags_nzcv),
        .pass_c (pass_c)
    );

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept_c     = bus.in_valid && bus.in_ready;

    // Output register and flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid     <= 1'b0;
            bus.out_ejecutar  <= 1'b0;
            bus.out_resultado <= '0;
            flags_nzcv        <= '0;
        end else if (accept_c) begin
            bus.out_valid     <= 1'b1;
            bus.out_ejecutar  <= pass_c;
            bus.out_resultado <= bus.in_resultado;
            if (pass_c && bus.in_setflags) begin
                flags_nzcv <= {bus.in_flagNegativo, bus.in_flagCero,
                               bus.in_flagCarry, bus.in_flagOverflow};
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef EVALUADOR_CONTADORES_EN
    // Saturating executed/annulled counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ejecutadas <= '0;
            cnt_anuladas   <= '0;
        end else if (accept_c) begin
            if (pass_c) begin
                if (cnt_ejecutadas != '1) begin
                    cnt_ejecutadas <= cnt_ejecutadas + CNT_W'(1);
                end
            end else begin
                if (cnt_anuladas != '1) begin
                    cnt_anuladas <= cnt_anuladas + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule
